exec_div_unit: RTL

- Iterative multi-cycle divider for the Execute stage, implementing MIPS DIV and DIVU.
- Produces quotient (LO) and remainder (HI), and raises `has_div_e` for one cycle so the Memory-stage pipeline register captures the result with the divide instruction.
- Holds `busy` while computing so the hazard unit stalls Fetch/Decode/Execute.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 32 +++
 rtl/exec_div_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             trial_neg;

  // One extra guard bit: with a zero divisor the remainder can reach 2^(WIDTH+1)-1,
  // and every step must still be accepted so the quotient saturates to all ones.
  always_comb begin
    rem_sh    = {rem, quo[WIDTH-1]};
    trial     = {1'b0, rem_sh} - {2'b00, divisor_mag};
    trial_neg = trial[WIDTH+1];
    if (trial_neg) begin
      next_rem = rem_sh[WIDTH-1:0];
      next_quo = {quo[WIDTH-2:0], 1'b0};
    end else begin
      next_rem = WIDTH'(trial);
      next_quo = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/exec_div_unit.sv
module exec_div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             has_div_e,
  output logic [WIDTH-1:0] div_hi_e,
  output logic [WIDTH-1:0] div_lo_e
);

  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem        (rem_q),
    .quo        (quo_q),
    .divisor_mag(dmag_q),
    .next_rem   (step_rem),
    .next_quo   (step_quo)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dmag_d     = dmag_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      IDLE, DONE: begin
        if (start && !flush) begin
          state_d    = ITER;
          count_d    = '0;
          rem_d      = '0;
          quo_d      = (is_signed && dividend[WIDTH-1]) ? (-dividend) : dividend;
          dmag_d     = (is_signed && divisor[WIDTH-1])  ? (-divisor)  : divisor;
          neg_quo_d  = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d  = is_signed && dividend[WIDTH-1];
          div_zero_d = (divisor == '0);
        end else begin
          state_d = IDLE;
        end
      end
      ITER: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_LAST) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          lo_d    = (neg_quo_q && !div_zero_q) ? (-quo_q) : quo_q;
          hi_d    = neg_rem_q ? (-rem_q) : rem_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dmag_q     <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dmag_q     <= dmag_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy      = (state_q == ITER) || (state_q == FIX);
  assign has_div_e = (state_q == DONE);
  assign div_hi_e  = hi_q;
  assign div_lo_e  = lo_q;

endmodule
